// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the stepping register bank.
// Holds the step-direction encoding and the address-width rule.
package reg_bank_pkg;

   localparam logic DIR_UP = 1'b0;
   localparam logic DIR_DN = 1'b1;

   // Address width never collapses to zero, even for a single-entry bank.
   function automatic int unsigned addr_width(input int unsigned nreg);
      return (nreg <= 2) ? 1 : $clog2(nreg);
   endfunction

endpackage

// File: rtl/reg_bank_step_if.sv
// Bus-side signal bundle of the register bank: write port, step port, read port.
// The master modport drives requests; the slave modport is the bank itself.
interface reg_bank_step_if
   import reg_bank_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned NREG  = 4
);
   localparam int unsigned AW = addr_width(NREG);

   logic             Clr;
   logic             Wen;
   logic [AW-1:0]    Waddr;
   logic [WIDTH-1:0] BusOut;
   logic             Step;
   logic             Dir;
   logic [AW-1:0]    Saddr;
   logic [AW-1:0]    Raddr;
   logic [WIDTH-1:0] dout;
   logic             dzero;
   logic             dovf;
   logic             collide;

   modport master (
      output Clr, Wen, Waddr, BusOut, Step, Dir, Saddr, Raddr,
      input  dout, dzero, dovf, collide
   );

   modport slave (
      input  Clr, Wen, Waddr, BusOut, Step, Dir, Saddr, Raddr,
      output dout, dzero, dovf, collide
   );

endinterface

// File: rtl/reg_bank_step_cell.sv
// One bank entry: value register plus sticky overflow flag.
// Priority clear > write > step; step arithmetic wraps or clamps.
module reg_step_cell
   import reg_bank_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      SATURATE  = 0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             wen,
   input  logic [WIDTH-1:0] wdata,
   input  logic             step,
   input  logic             dir,
   output logic [WIDTH-1:0] value,
   output logic             ovf
);

   localparam int unsigned XW = WIDTH + 1;

   logic [XW-1:0]    inc_w;
   logic [XW-1:0]    dec_w;
   logic [WIDTH-1:0] value_d;
   logic             ovf_d;

   // Extra top bit of inc_w/dec_w is the carry/borrow out of the step.
   always_comb begin
      inc_w   = {1'b0, value} + XW'(1);
      dec_w   = {1'b0, value} - XW'(1);
      value_d = value;
      ovf_d   = ovf;
      if (clr) begin
         value_d = RESET_VAL;
         ovf_d   = 1'b0;
      end else if (wen) begin
         value_d = wdata;
         ovf_d   = 1'b0;
      end else if (step) begin
         if (dir == DIR_UP) begin
            if (inc_w[WIDTH]) begin
               ovf_d   = 1'b1;
               value_d = (SATURATE != 0) ? '1 : inc_w[WIDTH-1:0];
            end else begin
               value_d = inc_w[WIDTH-1:0];
            end
         end else begin
            if (dec_w[WIDTH]) begin
               ovf_d   = 1'b1;
               value_d = (SATURATE != 0) ? '0 : dec_w[WIDTH-1:0];
            end else begin
               value_d = dec_w[WIDTH-1:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= RESET_VAL;
         ovf   <= 1'b0;
      end else begin
         value <= value_d;
         ovf   <= ovf_d;
      end
   end

endmodule

// File: rtl/reg_bank_step.sv
// General-purpose counter/register store: NREG entries with bus write, +/-1 step,
// global clear, sticky per-entry overflow and a combinational read port.
module reg_bank_step
   import reg_bank_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      NREG      = 4,
   parameter int unsigned      SATURATE  = 0,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic           Clk,
   input  logic           RSTn,
   reg_bank_step_if.slave bus
);

   localparam int unsigned AW = addr_width(NREG);

   logic [WIDTH-1:0] reg_q [NREG];
   logic [NREG-1:0]  ovf_q;
   logic [NREG-1:0]  wen_sel;
   logic [NREG-1:0]  step_sel;
   logic             collide_d;
   logic             collide_q;

   // Out-of-range addresses decode to no entry, so they never change state.
   always_comb begin
      wen_sel  = '0;
      step_sel = '0;
      for (int unsigned i = 0; i < NREG; i++) begin
         wen_sel[i]  = bus.Wen  && (bus.Waddr == AW'(i));
         step_sel[i] = bus.Step && (bus.Saddr == AW'(i));
      end
   end

   for (genvar g = 0; g < int'(NREG); g++) begin : g_cell
      reg_step_cell #(
         .WIDTH     (WIDTH),
         .SATURATE  (SATURATE),
         .RESET_VAL (RESET_VAL)
      ) u_cell (
         .clk   (Clk),
         .rst_n (RSTn),
         .clr   (bus.Clr),
         .wen   (wen_sel[g]),
         .wdata (bus.BusOut),
         .step  (step_sel[g]),
         .dir   (bus.Dir),
         .value (reg_q[g]),
         .ovf   (ovf_q[g])
      );
   end

   // A dropped step is flagged only when both requests hit the same valid entry.
   assign collide_d = !bus.Clr && (|(wen_sel & step_sel));

   always_ff @(posedge Clk or negedge RSTn) begin
      if (!RSTn) begin
         collide_q <= 1'b0;
      end else begin
         collide_q <= collide_d;
      end
   end

   assign bus.collide = collide_q;

   // Read mux: unmatched (out-of-range) address reads as zero with no overflow.
   always_comb begin
      bus.dout = '0;
      bus.dovf = 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
         if (bus.Raddr == AW'(i)) begin
            bus.dout = reg_q[i];
            bus.dovf = ovf_q[i];
         end
      end
      bus.dzero = (bus.dout == '0);
   end

endmodule

// File: doc/reg_bank_step.md
Name: reg_bank_step

Overview:
- Parametrised successor to the single 8-bit load/increment/reset register.
- Holds NREG registers of WIDTH bits. One bus write port, one increment/decrement step port, one global synchronous clear.
- Wrap or saturate arithmetic, with a per-register sticky overflow flag.
- Sits between the bus and the datapath as the general-purpose counter/register store; one combinational read port.

Parameters:
- WIDTH, 8, data width of each register (>=2)
- NREG, 4, number of registers (>=2; need not be a power of two)
- SATURATE, 0, 0 = wrap on overflow/underflow, 1 = clamp at all-ones/zero
- RESET_VAL, 0, value loaded into every register on reset and on Clr

Ports:
- Clk  in  1  clock, rising-edge active
- RSTn  in  1  asynchronous active-low reset
- Clr  in  1  synchronous clear of all registers and overflow flags
- Wen  in  1  write enable
- Waddr  in  AW  write address, AW = max(1,$clog2(NREG))
- BusOut  in  WIDTH  write data
- Step  in  1  step enable
- Dir  in  1  step direction, 0 = +1, 1 = -1
- Saddr  in  AW  step address
- Raddr  in  AW  read address
- dout  out  WIDTH  contents of register Raddr
- dzero  out  1  dout == 0
- dovf  out  1  sticky overflow flag of register Raddr
- collide  out  1  registered pulse: write and step targeted same register last cycle

Behaviour:
- Reset (RSTn=0, asynchronous):
  - All registers = RESET_VAL.
  - All ovf flags = 0; collide = 0.
  - dout/dzero/dovf immediately reflect the reset state at Raddr.
- Priority per register at each rising edge: Clr > Wen > Step.
- Clr=1:
  - All registers = RESET_VAL, all ovf = 0.
  - Wen/Step ignored that cycle.
  - collide = 0.
- Wen=1, Waddr valid: reg[Waddr] = BusOut, ovf[Waddr] cleared.
- Step=1, Saddr valid, no Wen to the same address:
  - Dir=0, reg != all-ones: reg + 1.
  - Dir=1, reg != 0: reg - 1.
  - Boundary, SATURATE=0: wraps modulo 2^WIDTH (all-ones+1 = 0; 0-1 = all-ones), ovf set.
  - Boundary, SATURATE=1: value held at all-ones or 0, ovf set.
  - ovf is sticky until Wen to that register, Clr, or reset.
- Write and step in the same cycle:
  - Different addresses: both take effect.
  - Same address: write wins, step dropped, collide = 1 next cycle for exactly one cycle.
  - Otherwise collide = 0.
- Address range: Waddr/Saddr >= NREG is ignored (no state change, no collide).
- Read port:
  - Raddr >= NREG: dout = 0, dzero = 1, dovf = 0.
  - Read is combinational from current state, with no write bypass. A write at edge N is visible on dout after edge N.
- Latency: single cycle for all updates; no handshake, every request accepted.
- Arithmetic is done at WIDTH+1 bits to detect carry/borrow. The result is truncated for wrap, or the clamp is selected for saturate.

Decomposition:
- Package reg_bank_pkg:
  - localparam helper function for AW
  - Dir encoding constants DIR_UP = 1'b0, DIR_DN = 1'b1
- One natural sub-module, reg_step_cell: one register plus its ovf flag, with the priority/arithmetic logic. It is instantiated NREG times via generate, decoded enables from the top.
- Read mux and collide register stay in the top.

Test Plan (WIDTH=8, NREG=4, SATURATE=0, RESET_VAL=0 unless noted):
- Pull RSTn low mid-cycle after loading reg1=0x55 -> reg1 reads 0x00 immediately, dovf=0, collide=0.
- Wen Waddr=2 BusOut=12; next cycle Step Dir=0 Saddr=2; then Step Dir=1 twice -> Raddr=2 reads 12, 13, 12, 11; dzero=0.
- Write reg3=0xFF, step up -> 0x00, dzero=1, dovf=1. Then Wen reg3=32 -> dovf=0. With SATURATE=1 the same stimulus -> holds 0xFF, dovf=1. Step down from 0 -> holds 0x00, dovf=1.
- Same cycle Wen Waddr=1 BusOut=32, Step Dir=0 Saddr=1 -> reg1=32 (not 33), collide=1 for one cycle. Same cycle to addresses 1 and 0 -> both update, collide=0.
- Clr=1 together with Wen Waddr=0 BusOut=7 -> all registers = RESET_VAL (0; rerun with RESET_VAL=8'hA5), write ignored, all ovf cleared.
- NREG=3: Wen Waddr=3 BusOut=9 -> no register changes; Raddr=3 -> dout=0, dzero=1. Finish with 10 cycles of random Wen/Step/Dir/Clr/addresses, compared against a reference model.
